// File: rtl/alu_pkg.sv
// Shared definitions for the ALU arbiter block.
// Contents:
//   alu_op_t  - ALUOp codes understood by the shared ALU
//   state_t   - arbiter FSM state encoding
//   op_issues - true when an op must actually be sent to the ALU
package alu_pkg;

  typedef enum logic [4:0] {
    OP_NOP   = 5'h00,
    OP_LUI   = 5'h01,
    OP_AUIPC = 5'h02,
    OP_ADD   = 5'h03,
    OP_SUB   = 5'h04
  } alu_op_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  // Highest op code the ALU accepts; anything above is answered locally
  // as an error and never reaches the ALU.
  localparam logic [4:0] OP_MAX_LEGAL = OP_SUB;

  // nop is legal but needs no ALU work, so it is not issued either.
  function automatic logic op_issues(input logic [4:0] op);
    return (op != OP_NOP) && (op <= OP_MAX_LEGAL);
  endfunction

endpackage

// File: rtl/alu_arbiter_if.sv
// Requester-side bus of the ALU arbiter: two request channels sharing one
// response channel.
// Signals:
//   req_valid/req_ready [1:0]  per-requester request handshake
//   req0_op/a/b, req1_op/a/b   op code and signed operands per requester
//   rsp_valid/rsp_ready [1:0]  per-requester response handshake
//   rsp_data, rsp_zero, rsp_err result, result==0 flag, illegal-op flag
// Modports: master = requester side, slave = arbiter side.
interface alu_arbiter_if;

  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [4:0]  req0_op;
  logic [31:0] req0_a;
  logic [31:0] req0_b;
  logic [4:0]  req1_op;
  logic [31:0] req1_a;
  logic [31:0] req1_b;
  logic [1:0]  rsp_valid;
  logic [1:0]  rsp_ready;
  logic [31:0] rsp_data;
  logic        rsp_zero;
  logic        rsp_err;

  modport master (
    output req_valid, req0_op, req0_a, req0_b, req1_op, req1_a, req1_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_zero, rsp_err
  );

  modport slave (
    input  req_valid, req0_op, req0_a, req0_b, req1_op, req1_a, req1_b, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_zero, rsp_err
  );

endinterface

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter (purely combinational).
// Ports:
//   req   [1:0] in   request bits
//   last        in   index of the requester served most recently
//   grant [1:0] out  one-hot grant, 0 when nothing requests
module rr_arbiter2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] grant
);

  always_comb begin
    grant = 2'b00;
    case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      // Under contention the requester that was not served last wins.
      2'b11:   grant = last ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end

endmodule

// File: rtl/alu_arbiter.sv
// Arbitrates two requesters onto one shared ALU, one operation at a time.
// Flow: IDLE accepts one request (round-robin) and latches it, EXEC drives
// the ALU for one cycle and captures its result, RESP holds the result
// until the granted requester takes it.
// Ports:
//   clk, rstn        clock, synchronous active-low reset
//   bus              requester bus (alu_arbiter_if.slave)
//   alu_a/b, alu_op  operands / op code to the shared ALU
//   alu_c, alu_zero  ALU result and zero flag (bit 0 used)
//   ops_done         count of completed response handshakes (wraps)
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rstn,
  alu_arbiter_if.slave     bus,
  output logic [31:0]      alu_a,
  output logic [31:0]      alu_b,
  output logic [4:0]       alu_op,
  input  logic [31:0]      alu_c,
  input  logic [7:0]       alu_zero,
  output logic [CNT_W-1:0] ops_done
);

  state_t           state_reg, state_next;
  logic [1:0]       grant;
  logic [1:0]       grant_reg;
  logic             last_reg;
  logic [4:0]       op_reg;
  logic [31:0]      a_reg, b_reg;
  logic [31:0]      data_reg;
  logic             zero_reg, err_reg;
  logic [CNT_W-1:0] cnt_reg;

  logic             load, capture, done, issue;
  logic [4:0]       sel_op;
  logic [31:0]      sel_a, sel_b;
  logic [1:0]       ready_bits, valid_bits;
  logic             unused_alu_zero;

  assign unused_alu_zero = ^alu_zero[7:1];

  rr_arbiter2 u_rr (
    .req   (bus.req_valid),
    .last  (last_reg),
    .grant (grant)
  );

  // Operands of the requester currently winning arbitration.
  assign sel_op = grant[1] ? bus.req1_op : bus.req0_op;
  assign sel_a  = grant[1] ? bus.req1_a  : bus.req0_a;
  assign sel_b  = grant[1] ? bus.req1_b  : bus.req0_b;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_reg <= ST_IDLE;
      grant_reg <= 2'b00;
      last_reg  <= 1'b1;  // "requester 1 served last" gives requester 0 priority
      op_reg    <= OP_NOP;
      a_reg     <= '0;
      b_reg     <= '0;
      data_reg  <= '0;
      zero_reg  <= 1'b0;
      err_reg   <= 1'b0;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      if (load) begin
        grant_reg <= grant;
        op_reg    <= sel_op;
        a_reg     <= sel_a;
        b_reg     <= sel_b;
      end
      if (capture) begin
        if (op_reg == OP_NOP) begin
          data_reg <= '0;
          zero_reg <= 1'b1;
          err_reg  <= 1'b0;
        end else if (op_issues(op_reg)) begin
          data_reg <= alu_c;
          zero_reg <= alu_zero[0];
          err_reg  <= 1'b0;
        end else begin
          data_reg <= '0;
          zero_reg <= 1'b1;
          err_reg  <= 1'b1;
        end
      end
      if (done) begin
        cnt_reg  <= cnt_reg + 1'b1;
        last_reg <= grant_reg[1];
      end
    end
  end

  always_comb begin
    state_next = state_reg;
    load       = 1'b0;
    capture    = 1'b0;
    done       = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (|bus.req_valid) begin
          load       = 1'b1;
          state_next = ST_EXEC;
        end
      end
      ST_EXEC: begin
        capture    = 1'b1;
        state_next = ST_RESP;
      end
      ST_RESP: begin
        // Only the granted requester's rsp_ready can close the transaction.
        if (|(bus.rsp_ready & grant_reg)) begin
          done       = 1'b1;
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // The ALU sees the operands only during EXEC, and only for ops it handles.
  assign issue  = (state_reg == ST_EXEC) && op_issues(op_reg);
  assign alu_a  = issue ? a_reg  : '0;
  assign alu_b  = issue ? b_reg  : '0;
  assign alu_op = issue ? op_reg : OP_NOP;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_hs
      assign ready_bits[gi] = (state_reg == ST_IDLE) && grant[gi];
      assign valid_bits[gi] = (state_reg == ST_RESP) && grant_reg[gi];
    end
  endgenerate

  assign bus.req_ready = ready_bits;
  assign bus.rsp_valid = valid_bits;
  assign bus.rsp_data  = (state_reg == ST_RESP) ? data_reg : '0;
  assign bus.rsp_zero  = (state_reg == ST_RESP) && zero_reg;
  assign bus.rsp_err   = (state_reg == ST_RESP) && err_reg;
  assign ops_done      = cnt_reg;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: a table of single transactions plus
// hand-written sequences for contention, backpressure and reset mid-op.
module tb_alu_arbiter;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        rstn;
  logic [31:0] alu_a, alu_b, alu_c;
  logic [4:0]  alu_op;
  logic [7:0]  alu_zero;
  logic [15:0] ops_done;

  int tests = 0;
  int fails = 0;
  int exp_ops = 0;

  alu_arbiter_if bus ();

  alu_arbiter #(.CNT_W(16)) dut (
    .clk      (clk),
    .rstn     (rstn),
    .bus      (bus),
    .alu_a    (alu_a),
    .alu_b    (alu_b),
    .alu_op   (alu_op),
    .alu_c    (alu_c),
    .alu_zero (alu_zero),
    .ops_done (ops_done)
  );

  always #5 clk = ~clk;

  // Reference ALU: lui passes b, auipc/add add, sub subtracts.
  always_comb begin
    alu_c = 32'd0;
    case (alu_op)
      5'h01:   alu_c = alu_b;
      5'h02:   alu_c = alu_a + alu_b;
      5'h03:   alu_c = alu_a + alu_b;
      5'h04:   alu_c = alu_a - alu_b;
      default: alu_c = 32'd0;
    endcase
    alu_zero = {7'd0, alu_c == 32'd0};
  end

  typedef struct {
    logic [1:0]  valid;
    logic [4:0]  op0;
    logic [31:0] a0, b0;
    logic [4:0]  op1;
    logic [31:0] a1, b1;
    logic [1:0]  grant;
    logic [31:0] data;
    logic        zero;
    logic        err;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [4:0] exp_alu(input logic [4:0] op);
    return (op >= 5'd1 && op <= 5'd4) ? op : 5'd0;
  endfunction

  task automatic check_idle_outputs(input string tag);
    check({tag, "_req_ready"}, {30'd0, bus.req_ready}, 32'd0);
    check({tag, "_rsp_valid"}, {30'd0, bus.rsp_valid}, 32'd0);
    check({tag, "_rsp_data"},  bus.rsp_data, 32'd0);
    check({tag, "_rsp_zero"},  {31'd0, bus.rsp_zero}, 32'd0);
    check({tag, "_rsp_err"},   {31'd0, bus.rsp_err}, 32'd0);
    check({tag, "_alu_a"},     alu_a, 32'd0);
    check({tag, "_alu_b"},     alu_b, 32'd0);
    check({tag, "_alu_op"},    {27'd0, alu_op}, 32'd0);
    check({tag, "_ops_done"},  {16'd0, ops_done}, 32'd0);
  endtask

  task automatic apply_reset();
    @(posedge clk); #1;
    rstn = 1'b0;
    bus.req_valid = 2'b00;
    bus.rsp_ready = 2'b00;
    @(posedge clk); #1;
    @(negedge clk);
    check_idle_outputs("in_reset");
    @(posedge clk); #1;
    rstn = 1'b1;
    exp_ops = 0;
    @(negedge clk);
    check_idle_outputs("after_reset");
  endtask

  // One full transaction: request, accept, EXEC, RESP at +2, handshake.
  task automatic run_txn(input string name, input vec_t v);
    int n = 0;
    @(posedge clk); #1;
    bus.req0_op = v.op0; bus.req0_a = v.a0; bus.req0_b = v.b0;
    bus.req1_op = v.op1; bus.req1_a = v.a1; bus.req1_b = v.b1;
    bus.req_valid = v.valid;
    bus.rsp_ready = 2'b00;
    @(negedge clk);
    while (bus.req_ready == 2'b00 && n < 8) begin
      @(negedge clk);
      n++;
    end
    check({name, "_grant"}, {30'd0, bus.req_ready}, {30'd0, v.grant});
    check({name, "_idle_alu_op"}, {27'd0, alu_op}, 32'd0);
    @(posedge clk); #1;
    bus.req_valid = 2'b00;
    @(negedge clk);  // EXEC
    check({name, "_exec_rsp_valid"}, {30'd0, bus.rsp_valid}, 32'd0);
    check({name, "_exec_alu_op"}, {27'd0, alu_op},
          {27'd0, exp_alu(v.grant[1] ? v.op1 : v.op0)});
    @(negedge clk);  // RESP, two cycles after acceptance
    check({name, "_rsp_valid"}, {30'd0, bus.rsp_valid}, {30'd0, v.grant});
    check({name, "_rsp_data"}, bus.rsp_data, v.data);
    check({name, "_rsp_zero"}, {31'd0, bus.rsp_zero}, {31'd0, v.zero});
    check({name, "_rsp_err"},  {31'd0, bus.rsp_err},  {31'd0, v.err});
    $display("[TB] %s grant=%b data=%h zero=%b err=%b", name, bus.req_ready == 2'b00 ? v.grant : v.grant,
             bus.rsp_data, bus.rsp_zero, bus.rsp_err);
    @(posedge clk); #1;
    bus.rsp_ready = v.grant;
    @(posedge clk); #1;
    bus.rsp_ready = 2'b00;
    exp_ops++;
    check({name, "_ops_done"}, {16'd0, ops_done}, 32'(exp_ops));
    check({name, "_done_rsp_valid"}, {30'd0, bus.rsp_valid}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t v;
    int ng, cyc, last_cyc;
    logic [1:0] exp_g;

    rstn = 1'b0;
    bus.req_valid = 2'b00;
    bus.rsp_ready = 2'b00;
    bus.req0_op = 5'd0; bus.req0_a = 32'd0; bus.req0_b = 32'd0;
    bus.req1_op = 5'd0; bus.req1_a = 32'd0; bus.req1_b = 32'd0;

    //            valid  op0    a0            b0            op1    a1            b1          grant  data          z     e
    vecs[0] = '{2'b01, 5'h03, 32'd5,        32'd7,        5'h00, 32'd0,        32'd0,        2'b01, 32'd12,       1'b0, 1'b0};
    vecs[1] = '{2'b10, 5'h00, 32'd0,        32'd0,        5'h04, 32'd9,        32'd9,        2'b10, 32'd0,        1'b1, 1'b0};
    vecs[2] = '{2'b01, 5'h1F, 32'd8,        32'd8,        5'h00, 32'd0,        32'd0,        2'b01, 32'd0,        1'b1, 1'b1};
    vecs[3] = '{2'b11, 5'h03, 32'd1,        32'd2,        5'h03, 32'd100,      32'hFFFFFF9C, 2'b10, 32'd0,        1'b1, 1'b0};
    vecs[4] = '{2'b11, 5'h04, 32'd3,        32'd10,       5'h03, 32'd6,        32'd6,        2'b01, 32'hFFFFFFF9, 1'b0, 1'b0};
    vecs[5] = '{2'b10, 5'h00, 32'd0,        32'd0,        5'h00, 32'd4,        32'd5,        2'b10, 32'd0,        1'b1, 1'b0};
    vecs[6] = '{2'b01, 5'h01, 32'd0,        32'h12345000, 5'h00, 32'd0,        32'd0,        2'b01, 32'h12345000, 1'b0, 1'b0};
    vecs[7] = '{2'b10, 5'h00, 32'd0,        32'd0,        5'h02, 32'h1000,     32'h20,       2'b10, 32'h1020,     1'b0, 1'b0};
    vecs[8] = '{2'b11, 5'h05, 32'd3,        32'd4,        5'h03, 32'd1,        32'd1,        2'b01, 32'd0,        1'b1, 1'b1};

    apply_reset();

    // Single add straight out of reset.
    run_txn("single_add", vecs[0]);

    // Contention from reset: both held valid, responses taken at once.
    apply_reset();
    @(posedge clk); #1;
    bus.req0_op = 5'h03; bus.req0_a = 32'd1; bus.req0_b = 32'd1;
    bus.req1_op = 5'h03; bus.req1_a = 32'd2; bus.req1_b = 32'd2;
    bus.req_valid = 2'b11;
    bus.rsp_ready = 2'b11;
    ng = 0; cyc = 0; last_cyc = 0; exp_g = 2'b01;
    while (ng < 4 && cyc < 40) begin
      @(negedge clk);
      if (bus.req_ready != 2'b00) begin
        check("contention_grant", {30'd0, bus.req_ready}, {30'd0, exp_g});
        if (ng > 0) check("contention_interval", 32'(cyc - last_cyc), 32'd3);
        $display("[TB] contention grant %0d = %b", ng, bus.req_ready);
        last_cyc = cyc;
        ng++;
        exp_g = {exp_g[0], exp_g[1]};
      end
      cyc++;
    end
    if (ng < 4) check("contention_grants_seen", 32'(ng), 32'd4);
    @(posedge clk); #1;
    bus.req_valid = 2'b00;
    @(posedge clk);
    @(posedge clk); #1;
    bus.rsp_ready = 2'b00;
    exp_ops += 4;
    check("contention_ops_done", {16'd0, ops_done}, 32'(exp_ops));

    // Table of single transactions; grants follow from the round-robin history.
    for (int i = 0; i < 9; i++) begin
      run_txn($sformatf("vec%0d", i), vecs[i]);
    end

    // Backpressure: response held five cycles, other requester's ready ignored.
    @(posedge clk); #1;
    bus.req0_op = 5'h03; bus.req0_a = 32'd20; bus.req0_b = 32'd22;
    bus.req1_op = 5'h03; bus.req1_a = 32'd1;  bus.req1_b = 32'd1;
    bus.req_valid = 2'b01;
    @(negedge clk);
    check("bp_grant", {30'd0, bus.req_ready}, 32'd1);
    @(posedge clk); #1;
    bus.req_valid = 2'b11;
    bus.rsp_ready = 2'b10;
    @(negedge clk);
    check("bp_exec_req_ready", {30'd0, bus.req_ready}, 32'd0);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("bp_rsp_valid", {30'd0, bus.rsp_valid}, 32'd1);
      check("bp_rsp_data", bus.rsp_data, 32'd42);
      check("bp_req_ready", {30'd0, bus.req_ready}, 32'd0);
    end
    @(posedge clk); #1;
    bus.req_valid = 2'b00;
    bus.rsp_ready = 2'b01;
    @(negedge clk);
    check("bp_rsp_valid_before_hs", {30'd0, bus.rsp_valid}, 32'd1);
    @(posedge clk); #1;
    bus.rsp_ready = 2'b00;
    exp_ops++;
    check("bp_ops_done", {16'd0, ops_done}, 32'(exp_ops));
    check("bp_done_rsp_valid", {30'd0, bus.rsp_valid}, 32'd0);
    $display("[TB] backpressure txn complete ops_done=%0d", ops_done);

    // Reset while in EXEC abandons the operation.
    @(posedge clk); #1;
    bus.req1_op = 5'h03; bus.req1_a = 32'd1; bus.req1_b = 32'd1;
    bus.req_valid = 2'b10;
    @(negedge clk);
    check("rst_exec_grant", {30'd0, bus.req_ready}, 32'd2);
    @(posedge clk); #1;
    bus.req_valid = 2'b00;
    rstn = 1'b0;
    @(negedge clk);
    check("rst_exec_alu_op", {27'd0, alu_op}, 32'h3);
    @(posedge clk); #1;
    rstn = 1'b1;
    exp_ops = 0;
    @(negedge clk);
    check_idle_outputs("rst_exec");
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("rst_exec_no_rsp", {30'd0, bus.rsp_valid}, 32'd0);
    end
    $display("[TB] reset in EXEC abandoned ops_done=%0d", ops_done);

    // After reset requester 0 has priority again.
    v = '{2'b11, 5'h03, 32'd2, 32'd3, 5'h04, 32'd1, 32'd1, 2'b01, 32'd5, 1'b0, 1'b0};
    run_txn("post_reset_priority", v);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
